avalon_mm_reg_master: RTL and testbench

AVALON_MM_REG_MASTER -- requirements
Module: avalon_mm_reg_master

---
 rtl/avalon_mm_reg_master.sv | 173 +++++++++++++++++
 tb/tb_avalon_mm_reg_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_reg_master.sv
// Single-outstanding Avalon-MM register master: forwards read/write commands to the bus
// and, when enabled, services the slave interrupt with a status read followed by a W1C write.
module avalon_mm_reg_master #(
   parameter int AV_ADDRESS_WIDTH = 5,
   parameter int AV_DATA_WIDTH    = 16,
   parameter int READ_LATENCY     = 1,
   parameter int IRQ_ADDRESS      = 2,
   parameter int AUTO_IRQ_CLEAR   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [AV_ADDRESS_WIDTH-1:0] cmd_address,
   input  logic [AV_DATA_WIDTH-1:0]    cmd_writedata,
   output logic                        rsp_valid,
   output logic [AV_DATA_WIDTH-1:0]    rsp_readdata,
   output logic [AV_ADDRESS_WIDTH-1:0] av_address,
   output logic                        av_read,
   output logic                        av_write,
   output logic [AV_DATA_WIDTH-1:0]    av_writedata,
   input  logic [AV_DATA_WIDTH-1:0]    av_readdata,
   input  logic                        av_irq,
   output logic                        irq_valid,
   output logic [AV_DATA_WIDTH-1:0]    irq_status,
   output logic                        busy
);

   typedef enum logic [2:0] {
      IDLE,
      CMD_WR,
      CMD_RD,
      CMD_RD_WAIT,
      IRQ_RD,
      IRQ_RD_WAIT,
      IRQ_CLR
   } state_t;

   localparam logic [2:0]                  LAT      = 3'(READ_LATENCY);
   localparam logic [AV_ADDRESS_WIDTH-1:0] IRQ_ADDR = AV_ADDRESS_WIDTH'(IRQ_ADDRESS);

   state_t                      state_q, state_d;
   logic                        live_q, live_d;
   logic [2:0]                  cnt_q, cnt_d;
   logic [AV_ADDRESS_WIDTH-1:0] av_address_q, av_address_d;
   logic [AV_DATA_WIDTH-1:0]    av_writedata_q, av_writedata_d;
   logic                        av_read_q, av_read_d;
   logic                        av_write_q, av_write_d;
   logic                        rsp_valid_q, rsp_valid_d;
   logic [AV_DATA_WIDTH-1:0]    rsp_readdata_q, rsp_readdata_d;
   logic                        irq_valid_q, irq_valid_d;
   logic [AV_DATA_WIDTH-1:0]    irq_status_q, irq_status_d;
   logic                        busy_q, busy_d;
   logic                        irq_take;

   // live_q holds cmd_ready low until the first edge after reset release.
   assign irq_take  = (AUTO_IRQ_CLEAR != 0) && av_irq;
   assign cmd_ready = live_q && (state_q == IDLE) && !irq_take;

   always_comb begin
      // NOTE: every _d gets a default here so no path through the case infers a latch.
      state_d        = state_q;
      live_d         = 1'b1;
      cnt_d          = cnt_q;
      av_address_d   = av_address_q;
      av_writedata_d = av_writedata_q;
      av_read_d      = 1'b0;
      av_write_d     = 1'b0;
      rsp_valid_d    = 1'b0;
      rsp_readdata_d = rsp_readdata_q;
      irq_valid_d    = 1'b0;
      irq_status_d   = irq_status_q;

      case (state_q)
         IDLE: begin
            if (live_q && irq_take) begin
               state_d      = IRQ_RD;
               av_address_d = IRQ_ADDR;
               av_read_d    = 1'b1;
            end else if (live_q && cmd_valid) begin
               av_address_d   = cmd_address;
               av_writedata_d = cmd_writedata;
               if (cmd_write) begin
                  state_d    = CMD_WR;
                  av_write_d = 1'b1;
               end else begin
                  state_d   = CMD_RD;
                  av_read_d = 1'b1;
               end
            end
         end
         CMD_WR: state_d = IDLE;
         CMD_RD: begin
            state_d = CMD_RD_WAIT;
            cnt_d   = LAT;
         end
         CMD_RD_WAIT: begin
            if (cnt_q <= 3'd1) begin
               state_d        = IDLE;
               cnt_d          = 3'd0;
               rsp_valid_d    = 1'b1;
               rsp_readdata_d = av_readdata;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         IRQ_RD: begin
            state_d = IRQ_RD_WAIT;
            cnt_d   = LAT;
         end
         IRQ_RD_WAIT: begin
            // The captured status becomes both the W1C write data and the reported snapshot.
            if (cnt_q <= 3'd1) begin
               state_d        = IRQ_CLR;
               cnt_d          = 3'd0;
               av_write_d     = 1'b1;
               av_writedata_d = av_readdata;
               irq_valid_d    = 1'b1;
               irq_status_d   = av_readdata;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         IRQ_CLR: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         live_q         <= 1'b0;
         cnt_q          <= 3'd0;
         av_address_q   <= '0;
         av_writedata_q <= '0;
         av_read_q      <= 1'b0;
         av_write_q     <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_readdata_q <= '0;
         irq_valid_q    <= 1'b0;
         irq_status_q   <= '0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         live_q         <= live_d;
         cnt_q          <= cnt_d;
         av_address_q   <= av_address_d;
         av_writedata_q <= av_writedata_d;
         av_read_q      <= av_read_d;
         av_write_q     <= av_write_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_readdata_q <= rsp_readdata_d;
         irq_valid_q    <= irq_valid_d;
         irq_status_q   <= irq_status_d;
         busy_q         <= busy_d;
      end
   end

   assign av_address   = av_address_q;
   assign av_writedata = av_writedata_q;
   assign av_read      = av_read_q;
   assign av_write     = av_write_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_readdata = rsp_readdata_q;
   assign irq_valid    = irq_valid_q;
   assign irq_status   = irq_status_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_avalon_mm_reg_master.sv
// Bench for avalon_mm_reg_master: a latency-1 interrupt-servicing instance and a latency-3
// instance with interrupt service disabled, both against a timed slave and a register model.
module tb_avalon_mm_reg_master;
   localparam int AW    = 5;
   localparam int DW    = 16;
   localparam int IRQ_A = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // sel picks which instance receives commands and is observed: 0 = latency 1, 1 = latency 3.
   logic          sel = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_address = '0;
   logic [DW-1:0] cmd_writedata = '0;
   logic [DW-1:0] av_readdata = '0;
   logic          av_irq = 1'b0;

   logic          cr [2];
   logic          rv [2];
   logic [DW-1:0] rd [2];
   logic [AW-1:0] ava [2];
   logic          avr [2];
   logic          avw [2];
   logic [DW-1:0] avwd [2];
   logic          iv [2];
   logic [DW-1:0] ist [2];
   logic          bz [2];

   logic          o_cmd_ready, o_rsp_valid, o_av_read, o_av_write, o_irq_valid, o_busy;
   logic [DW-1:0] o_rsp_readdata, o_av_writedata, o_irq_status;
   logic [AW-1:0] o_av_address;

   assign o_cmd_ready    = cr[sel];
   assign o_rsp_valid    = rv[sel];
   assign o_rsp_readdata = rd[sel];
   assign o_av_address   = ava[sel];
   assign o_av_read      = avr[sel];
   assign o_av_write     = avw[sel];
   assign o_av_writedata = avwd[sel];
   assign o_irq_valid    = iv[sel];
   assign o_irq_status   = ist[sel];
   assign o_busy         = bz[sel];

   avalon_mm_reg_master #(
      .AV_ADDRESS_WIDTH(AW), .AV_DATA_WIDTH(DW), .READ_LATENCY(1),
      .IRQ_ADDRESS(IRQ_A), .AUTO_IRQ_CLEAR(1)
   ) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid && !sel), .cmd_ready(cr[0]), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
      .rsp_valid(rv[0]), .rsp_readdata(rd[0]),
      .av_address(ava[0]), .av_read(avr[0]), .av_write(avw[0]), .av_writedata(avwd[0]),
      .av_readdata(av_readdata), .av_irq(av_irq && !sel),
      .irq_valid(iv[0]), .irq_status(ist[0]), .busy(bz[0])
   );

   avalon_mm_reg_master #(
      .AV_ADDRESS_WIDTH(AW), .AV_DATA_WIDTH(DW), .READ_LATENCY(3),
      .IRQ_ADDRESS(IRQ_A), .AUTO_IRQ_CLEAR(0)
   ) u_dut_lat3 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid && sel), .cmd_ready(cr[1]), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
      .rsp_valid(rv[1]), .rsp_readdata(rd[1]),
      .av_address(ava[1]), .av_read(avr[1]), .av_write(avw[1]), .av_writedata(avwd[1]),
      .av_readdata(av_readdata), .av_irq(av_irq),
      .irq_valid(iv[1]), .irq_status(ist[1]), .busy(bz[1])
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Slave register file (driven by the bus) and the reference model (driven by commands).
   logic [DW-1:0] mem     [32];
   logic [DW-1:0] ref_mem [32];

   // Slave: read data is valid only in the one cycle READ_LATENCY cycles after the strobe;
   // every other cycle carries the complement so early or late sampling is visible.
   int            cyc = 0;
   int            due = -1;
   logic [AW-1:0] paddr = '0;
   always @(negedge clk) begin
      cyc++;
      if (cyc == due) av_readdata = mem[paddr];
      else            av_readdata = ~mem[o_av_address];
      if (o_av_read && o_av_write) check("both_strobes", 1, 0);
      if (o_av_read) begin
         due   = cyc + (sel ? 3 : 1);
         paddr = o_av_address;
      end
      if (o_av_write) begin
         if (o_av_address == AW'(IRQ_A)) mem[IRQ_A] = mem[IRQ_A] & ~o_av_writedata;
         else                             mem[o_av_address] = o_av_writedata;
      end
   end

   task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (a == AW'(IRQ_A)) ref_mem[a] = ref_mem[a] & ~d;
      else                 ref_mem[a] = d;
   endtask

   // Starts at a negedge; returns at the negedge of the strobe cycle.
   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d;
      #1;
      while (!o_cmd_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 50) check("accept_timeout", 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      issue(1'b1, a, d);
      check("wr_strobe", o_av_write, 1);
      check("wr_read_low", o_av_read, 0);
      check("wr_addr", o_av_address, a);
      check("wr_data", o_av_writedata, d);
      check("wr_busy", o_busy, 1);
      check("wr_ready_low", o_cmd_ready, 0);
      @(negedge clk);
      check("wr_single", o_av_write, 0);
      check("wr_idle", o_busy, 0);
      check("wr_ready_back", o_cmd_ready, 1);
      ref_write(a, d);
   endtask

   task automatic run_read(input logic [AW-1:0] a);
      int rl = sel ? 3 : 1;
      issue(1'b0, a, 16'($urandom));
      check("rd_strobe", o_av_read, 1);
      check("rd_write_low", o_av_write, 0);
      check("rd_addr", o_av_address, a);
      for (int i = 0; i < rl; i++) begin
         @(negedge clk);
         check("rd_wait_read_low", o_av_read, 0);
         check("rd_wait_no_rsp", o_rsp_valid, 0);
         check("rd_wait_busy", o_busy, 1);
         check("rd_wait_addr", o_av_address, a);
      end
      @(negedge clk);
      check("rd_rsp_valid", o_rsp_valid, 1);
      check("rd_rsp_data", o_rsp_readdata, ref_mem[a]);
      check("rd_done_idle", o_busy, 0);
      @(negedge clk);
      check("rd_rsp_pulse", o_rsp_valid, 0);
   endtask

   // Interrupt service on the latency-1 instance, optionally with a command already waiting.
   task automatic run_irq(input logic [DW-1:0] status, input logic with_cmd, input logic cw,
                          input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      mem[IRQ_A] = status; ref_mem[IRQ_A] = status;
      av_irq = 1'b1;
      if (with_cmd) begin
         cmd_valid = 1'b1; cmd_write = cw; cmd_address = ca; cmd_writedata = cd;
      end
      #1;
      check("irq_blocks_ready", o_cmd_ready, 0);
      @(negedge clk);
      check("irq_rd_strobe", o_av_read, 1);
      check("irq_rd_addr", o_av_address, IRQ_A);
      check("irq_rd_no_write", o_av_write, 0);
      check("irq_rd_busy", o_busy, 1);
      check("irq_rd_ready_low", o_cmd_ready, 0);
      @(negedge clk);
      check("irq_wait_read_low", o_av_read, 0);
      check("irq_wait_no_write", o_av_write, 0);
      check("irq_wait_ready_low", o_cmd_ready, 0);
      @(negedge clk);
      check("irq_clr_strobe", o_av_write, 1);
      check("irq_clr_addr", o_av_address, IRQ_A);
      check("irq_clr_data", o_av_writedata, status);
      check("irq_valid", o_irq_valid, 1);
      check("irq_status", o_irq_status, status);
      check("irq_clr_ready_low", o_cmd_ready, 0);
      av_irq = 1'b0;
      ref_mem[IRQ_A] = ref_mem[IRQ_A] & ~status;
      @(negedge clk);
      check("irq_valid_pulse", o_irq_valid, 0);
      check("irq_done_no_write", o_av_write, 0);
      check("irq_done_idle", o_busy, 0);
      check("irq_done_ready", o_cmd_ready, 1);
      if (with_cmd) begin
         if (cw) run_write(ca, cd);
         else    run_read(ca);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, o_cmd_ready, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_av_read"}, o_av_read, 0);
      check({tag, "_av_write"}, o_av_write, 0);
      check({tag, "_av_address"}, o_av_address, 0);
      check({tag, "_av_writedata"}, o_av_writedata, 0);
      check({tag, "_rsp_valid"}, o_rsp_valid, 0);
      check({tag, "_rsp_readdata"}, o_rsp_readdata, 0);
      check({tag, "_irq_valid"}, o_irq_valid, 0);
      check({tag, "_irq_status"}, o_irq_status, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] v;
      for (int i = 0; i < 32; i++) begin
         v = 16'($urandom);
         mem[i] = v; ref_mem[i] = v;
      end

      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;
      #1;
      check("por_ready_before_edge", o_cmd_ready, 0);
      @(negedge clk);
      check("por_ready_after_edge", o_cmd_ready, 1);

      // Directed: write, latency-1 read, interrupt with a waiting command, spurious interrupt.
      run_write(5'd3, 16'h1234);
      mem[1] = 16'h0001; ref_mem[1] = 16'h0001;
      run_read(5'd1);
      run_irq(16'h0006, 1'b1, 1'b1, 5'd7, 16'hBEEF);
      run_irq(16'h0000, 1'b0, 1'b0, 5'd0, 16'h0000);

      for (int t = 0; t < 40; t++) begin
         int kind = $urandom_range(0, 9);
         logic [AW-1:0] a = AW'($urandom_range(0, 31));
         if (kind < 4)      run_write(a, 16'($urandom));
         else if (kind < 8) run_read(a);
         else               run_irq(16'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Latency-3 instance: interrupt input must not affect it.
      sel = 1'b1;
      av_irq = 1'b1;
      #1;
      check("noauto_ready", o_cmd_ready, 1);
      repeat (3) begin
         @(negedge clk);
         check("noauto_idle", o_busy, 0);
         check("noauto_no_read", o_av_read, 0);
      end
      av_irq = 1'b0;
      run_read(5'd4);

      for (int t = 0; t < 12; t++) begin
         logic [AW-1:0] a = AW'($urandom_range(0, 31));
         av_irq = 1'($urandom);
         if ($urandom_range(0, 1) == 0) run_write(a, 16'($urandom));
         else                           run_read(a);
      end
      av_irq = 1'b0;

      // Reset in the middle of a latency-3 read.
      issue(1'b0, 5'd4, 16'h00FF);
      check("mid_rst_strobe", o_av_read, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_ready_before_edge", o_cmd_ready, 0);
      repeat (4) begin
         @(negedge clk);
         check("mid_rst_no_rsp", o_rsp_valid, 0);
      end
      run_read(5'd4);
      run_write(5'd9, 16'hA5A5);
      run_read(5'd9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
